// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and program memory write port out of the loader
interface prog_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [11:0] load_I;

    // master: byte source and program memory; slave: the loader itself
    modport master (output byte_valid, byte_data,
                    input  byte_ready, load_en, load_addr, load_I);
    modport slave  (input  byte_valid, byte_data,
                    output byte_ready, load_en, load_addr, load_I);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the 256x12 program memory with XOR check
module prog_loader (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    prog_loader_if.slave  bus,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_chk_err,
    output logic          o_fmt_err,
    output logic          o_run
);
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_byte_ready, w_byte_ready_nxt;
    logic        r_load_en, w_load_en_nxt;
    logic [7:0]  r_load_addr, w_load_addr_nxt;
    logic [11:0] r_load_I, w_load_I_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_chk_err, w_chk_err_nxt;
    logic        r_fmt_err, w_fmt_err_nxt;
    logic        r_run, w_run_nxt;
    logic [7:0]  r_ptr, w_ptr_nxt;
    logic [8:0]  r_remaining, w_remaining_nxt;
    logic [7:0]  r_acc, w_acc_nxt;
    logic [3:0]  r_hi, w_hi_nxt;
    logic        w_xfer, w_abort;

    assign w_xfer  = bus.byte_valid && r_byte_ready;
    assign w_abort = i_abort && (r_state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_load_en    <= 1'b0;
            r_load_addr  <= 8'h00;
            r_load_I     <= 12'h000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_chk_err    <= 1'b0;
            r_fmt_err    <= 1'b0;
            r_run        <= 1'b0;
            r_ptr        <= 8'h00;
            r_remaining  <= 9'd0;
            r_acc        <= 8'h00;
            r_hi         <= 4'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= w_byte_ready_nxt;
            r_load_en    <= w_load_en_nxt;
            r_load_addr  <= w_load_addr_nxt;
            r_load_I     <= w_load_I_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_chk_err    <= w_chk_err_nxt;
            r_fmt_err    <= w_fmt_err_nxt;
            r_run        <= w_run_nxt;
            r_ptr        <= w_ptr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_acc        <= w_acc_nxt;
            r_hi         <= w_hi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_COUNT;
            S_COUNT: if (w_xfer)  w_state_nxt = S_HI;
            S_HI:    if (w_xfer)  w_state_nxt = S_LO;
            S_LO:    if (w_xfer)  w_state_nxt = (r_remaining == 9'd1) ? S_CHK : S_HI;
            S_CHK:   if (w_xfer)  w_state_nxt = S_DONE;
            S_DONE:               w_state_nxt = S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // Computes next register values; ready is registered from the next state so it never looks at valid.
    always_comb begin
        w_byte_ready_nxt = (w_state_nxt == S_COUNT) || (w_state_nxt == S_HI) ||
                           (w_state_nxt == S_LO)    || (w_state_nxt == S_CHK);
        w_load_en_nxt    = 1'b0;
        w_load_addr_nxt  = r_load_addr;
        w_load_I_nxt     = r_load_I;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_chk_err_nxt    = r_chk_err;
        w_fmt_err_nxt    = r_fmt_err;
        w_run_nxt        = r_run;
        w_ptr_nxt        = r_ptr;
        w_remaining_nxt  = r_remaining;
        w_acc_nxt        = r_acc;
        w_hi_nxt         = r_hi;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_busy_nxt    = 1'b1;
                w_run_nxt     = 1'b0;
                w_chk_err_nxt = 1'b0;
                w_fmt_err_nxt = 1'b0;
                w_acc_nxt     = 8'h00;
                w_ptr_nxt     = 8'h00;
            end
            S_COUNT: if (w_xfer && !i_abort) begin
                w_remaining_nxt = (bus.byte_data == 8'h00) ? 9'd256 : {1'b0, bus.byte_data};
                w_acc_nxt       = r_acc ^ bus.byte_data;
            end
            S_HI: if (w_xfer && !i_abort) begin
                w_hi_nxt  = bus.byte_data[3:0];
                w_acc_nxt = r_acc ^ bus.byte_data;
                if (bus.byte_data[7:4] != 4'h0) w_fmt_err_nxt = 1'b1;
            end
            // A completed LO byte commits its write even when abort arrives alongside it.
            S_LO: if (w_xfer) begin
                w_load_en_nxt   = 1'b1;
                w_load_addr_nxt = r_ptr;
                w_load_I_nxt    = {r_hi, bus.byte_data};
                w_ptr_nxt       = r_ptr + 8'd1;
                w_remaining_nxt = r_remaining - 9'd1;
                w_acc_nxt       = r_acc ^ bus.byte_data;
            end
            S_CHK: if (w_xfer && !i_abort) begin
                w_chk_err_nxt = (bus.byte_data != r_acc);
                w_run_nxt     = (bus.byte_data == r_acc) && !r_fmt_err;
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
            end
            default: ;
        endcase
        if (w_abort) w_busy_nxt = 1'b0;
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.load_en    = r_load_en;
    assign bus.load_addr  = r_load_addr;
    assign bus.load_I     = r_load_I;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_chk_err      = r_chk_err;
    assign o_fmt_err      = r_fmt_err;
    assign o_run          = r_run;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, chk_err, fmt_err, run;

    prog_loader_if ld();

    prog_loader dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_abort   (abort),
        .bus       (ld),
        .o_busy    (busy),
        .o_done    (done),
        .o_chk_err (chk_err),
        .o_fmt_err (fmt_err),
        .o_run     (run)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    logic [19:0] wq[$];
    logic [2:0]  dq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ld.load_en) begin
                if (wq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_write: got addr %0h I %0h, required no write", ld.load_addr, ld.load_I);
                end else begin
                    logic [19:0] w_exp;
                    w_exp = wq.pop_front();
                    check("write_addr_I", {12'h0, ld.load_addr, ld.load_I}, {12'h0, w_exp});
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done=1, required 0");
                end else begin
                    logic [2:0] d_exp;
                    d_exp = dq.pop_front();
                    check("done_chk_fmt_run", {29'h0, chk_err, fmt_err, run}, {29'h0, d_exp});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            ld.byte_valid = 1'b0;
            start = poke_start;
        end
        @(negedge clk);
        start = 1'b0;
        ld.byte_valid = 1'b1;
        ld.byte_data = b;
        t = 0;
        while (!ld.byte_ready && t < 50) begin
            @(negedge clk);
            t++;
            stall_cnt++;
        end
        if (!ld.byte_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got byte_ready=0, required 1");
        end
    endtask

    task automatic begin_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", {31'h0, busy}, 32'h1);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gappy);
        for (int i = 0; i < f.size(); i++)
            send_byte(f[i], gappy ? (i % 3) : 0, gappy);
        @(negedge clk);
        ld.byte_valid = 1'b0;
    endtask

    task automatic end_frame(input logic e_chk, input logic e_fmt, input logic e_run);
        int t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy_fall", {31'h0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        check("chk_err", {31'h0, chk_err}, {31'h0, e_chk});
        check("fmt_err", {31'h0, fmt_err}, {31'h0, e_fmt});
        check("run", {31'h0, run}, {31'h0, e_run});
        check("writes_left", wq.size(), 32'h0);
        check("done_left", dq.size(), 32'h0);
    endtask

    task automatic check_reset_outs();
        check("reset_flags", {25'h0, ld.byte_ready, ld.load_en, busy, done, chk_err, fmt_err, run}, 32'h0);
        check("reset_addr", {24'h0, ld.load_addr}, 32'h0);
        check("reset_I", {20'h0, ld.load_I}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad_chk[$];
        logic [7:0] big[$];
        logic [7:0] bad_fmt[$];
        logic [7:0] ab[$];
        logic [7:0] cs;
        logic [11:0] ins;

        ld.byte_valid = 1'b0;
        ld.byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst_n = 1'b1;

        // 3-word frame with correct checksum
        good = '{8'h03, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h67};
        wq.push_back({8'h00, 12'hABC}); wq.push_back({8'h01, 12'h123}); wq.push_back({8'h02, 12'hFFF});
        dq.push_back(3'b001);
        begin_frame();
        send_frame(good, 1'b0);
        end_frame(1'b0, 1'b0, 1'b1);
        check("hold_addr", {24'h0, ld.load_addr}, 32'h02);
        check("hold_I", {20'h0, ld.load_I}, 32'hFFF);

        // same stream, wrong checksum
        bad_chk = '{8'h03, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00};
        wq.push_back({8'h00, 12'hABC}); wq.push_back({8'h01, 12'h123}); wq.push_back({8'h02, 12'hFFF});
        dq.push_back(3'b100);
        begin_frame();
        send_frame(bad_chk, 1'b0);
        end_frame(1'b1, 1'b0, 1'b0);

        // COUNT=0: 256 words, one byte per cycle
        big.push_back(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ins = 12'(i * 7 + 5);
            big.push_back({4'h0, ins[11:8]});
            big.push_back(ins[7:0]);
            cs = cs ^ {4'h0, ins[11:8]} ^ ins[7:0];
            wq.push_back({8'(i), ins});
        end
        big.push_back(cs);
        dq.push_back(3'b001);
        begin_frame();
        stall_cnt = 0;
        send_frame(big, 1'b0);
        check("full_rate_stalls", stall_cnt, 32'h0);
        end_frame(1'b0, 1'b0, 1'b1);

        // bad upper nibble in HI, then a good frame clears the flags
        bad_fmt = '{8'h01, 8'h1A, 8'h55, 8'h4E};
        wq.push_back({8'h00, 12'hA55});
        dq.push_back(3'b010);
        begin_frame();
        send_frame(bad_fmt, 1'b0);
        end_frame(1'b0, 1'b1, 1'b0);
        wq.push_back({8'h00, 12'hABC}); wq.push_back({8'h01, 12'h123}); wq.push_back({8'h02, 12'hFFF});
        dq.push_back(3'b001);
        begin_frame();
        send_frame(good, 1'b0);
        end_frame(1'b0, 1'b0, 1'b1);

        // valid gaps with start pokes while busy
        wq.push_back({8'h00, 12'hABC}); wq.push_back({8'h01, 12'h123}); wq.push_back({8'h02, 12'hFFF});
        dq.push_back(3'b001);
        begin_frame();
        send_frame(good, 1'b1);
        end_frame(1'b0, 1'b0, 1'b1);

        // abort in HI after 2 of 5 words; the concurrent byte is discarded
        ab = '{8'h05, 8'h01, 8'h11, 8'h02, 8'h22};
        wq.push_back({8'h00, 12'h111}); wq.push_back({8'h01, 12'h222});
        begin_frame();
        for (int i = 0; i < ab.size(); i++) send_byte(ab[i], 0, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        ld.byte_valid = 1'b1;
        ld.byte_data = 8'h03;
        @(negedge clk);
        abort = 1'b0;
        ld.byte_valid = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, ld.byte_ready}, 32'h0);
        repeat (5) @(negedge clk);
        check("abort_run", {31'h0, run}, 32'h0);
        check("abort_writes_left", wq.size(), 32'h0);

        // reset mid-LO
        wq.push_back({8'h00, 12'h345});
        begin_frame();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h45, 0, 1'b0);
        send_byte(8'h06, 0, 1'b0);
        @(negedge clk);
        ld.byte_data = 8'h78;
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        @(negedge clk);
        ld.byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outs();
        check("reset_writes_left", wq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
